// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the two-port memory arbiter:
//   state_t   - arbiter FSM states (IDLE, ISSUE, RESP)
//   port_id_t - requester port identifier
//   PORT_A    - instruction-fetch port ID
//   PORT_B    - data load/store port ID
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_A = 1'b0;
  localparam port_id_t PORT_B = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker (purely combinational).
// Ports:
//   req_a, req_b  in  : requests eligible for this arbitration
//   last_grant    in  : port granted most recently
//   enable        in  : arbitration allowed this cycle
//   grant         out : winning port ID (meaningful only when valid)
//   valid         out : a grant is made this cycle
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic     req_a,
  input  logic     req_b,
  input  port_id_t last_grant,
  input  logic     enable,
  output port_id_t grant,
  output logic     valid
);

  always_comb begin
    valid = enable & (req_a | req_b);
    grant = PORT_A;
    if (req_a && req_b) begin
      // Tie: the port that was not served last time wins.
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant = PORT_B;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-port registered RAM between an instruction-fetch port
// (A) and a data load/store port (B). One access takes ISSUE + RESP; the RESP
// cycle can re-arbitrate straight into the next ISSUE.
// Ports:
//   clk, clr                    : clock, asynchronous active-high reset
//   req_x, we_x, addr_x, wdata_x: requester A/B access (held until ack)
//   ack_a, ack_b                : one-cycle completion pulse
//   rd_data                     : read data, valid with a read ack
//   ram_addr, ram_wdata         : RAM address / write data (registered)
//   ram_we, ram_re              : RAM enables, high only in ISSUE
//   ram_rdata                   : registered RAM read data
//   busy                        : FSM not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_next;
  port_id_t          r_owner;
  port_id_t          r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_arb_en;
  logic              w_arb_req_a;
  logic              w_arb_req_b;
  port_id_t          w_grant;
  logic              w_grant_valid;

  // Arbitration happens in IDLE and in RESP. In RESP the owner is still
  // holding req high during its ack cycle, so only the other port counts.
  assign w_arb_en    = (r_state == IDLE) || (r_state == RESP);
  assign w_arb_req_a = req_a & ~((r_state == RESP) && (r_owner == PORT_A));
  assign w_arb_req_b = req_b & ~((r_state == RESP) && (r_owner == PORT_B));

  rr_arb2 u_rr_arb2 (
    .req_a      (w_arb_req_a),
    .req_b      (w_arb_req_b),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .valid      (w_grant_valid)
  );

  // State and latched-access registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= IDLE;
      r_owner      <= PORT_A;
      r_last_grant <= PORT_B;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_valid) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        if (w_grant == PORT_A) begin
          r_we    <= we_a;
          r_addr  <= addr_a;
          r_wdata <= wdata_a;
        end else begin
          r_we    <= we_b;
          r_addr  <= addr_b;
          r_wdata <= wdata_b;
        end
      end
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    ack_a        = 1'b0;
    ack_b        = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant_valid) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_we       = r_we;
        ram_re       = ~r_we;
        w_state_next = RESP;
      end
      RESP: begin
        ack_a        = (r_owner == PORT_A);
        ack_b        = (r_owner == PORT_B);
        w_state_next = w_grant_valid ? ISSUE : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Address/data come straight from the latch registers so the RAM never
  // sees a combinational path from the requester inputs.
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rd_data   = ram_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level timing model
// (grant -> issue one cycle later -> ack two cycles later, round-robin on
// ties) and a shadow memory for read data.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              clr;
  logic              req_a, req_b, we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic              ack_a, ack_b;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_a     (req_a),
    .req_b     (req_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .wdata_a   (wdata_a),
    .wdata_b   (wdata_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .rd_data   (rd_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // ---------------- RAM environment ----------------
  function automatic logic [31:0] init_val(input int a);
    logic [31:0] av;
    av = a;
    return 32'hA5A5_0000 ^ (av * 32'h0001_0003);
  endfunction

  logic [31:0] ram_mem     [256];
  bit          ram_written [256];

  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr]     <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
    if (ram_re) begin
      ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
    end
  end

  // ---------------- bench state ----------------
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          delay;
  } txn_t;

  typedef struct {
    bit          port;
    int          cyc;
    logic [31:0] data;
  } ack_t;

  txn_t qa[$];
  txn_t qb[$];
  ack_t ack_log[$];
  int   wait_a, wait_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   we_cycles = 0;

  // Model of the access in flight.
  bit          pend_valid;
  bit          pend_port;
  int          pend_g;
  logic        pend_we;
  logic [7:0]  pend_addr;
  logic [31:0] pend_wdata;
  bit          last_port;
  logic [31:0] shadow [int];

  function automatic logic [31:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit p, input logic we, input logic [7:0] a,
                      input logic [31:0] d, input int dly);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.delay = dly;
    if (p == 1'b0) begin
      if (qa.size() == 0) wait_a = dly;
      qa.push_back(t);
    end else begin
      if (qb.size() == 0) wait_b = dly;
      qb.push_back(t);
    end
  endtask

  task automatic drive_ports();
    if (wait_a > 0) begin
      req_a = 1'b0; wait_a--;
      we_a = 1'($urandom); addr_a = 8'($urandom); wdata_a = $urandom;
    end else if (qa.size() > 0) begin
      req_a = 1'b1; we_a = qa[0].we; addr_a = qa[0].addr; wdata_a = qa[0].wdata;
    end else begin
      req_a = 1'b0;
      we_a = 1'($urandom); addr_a = 8'($urandom); wdata_a = $urandom;
    end
    if (wait_b > 0) begin
      req_b = 1'b0; wait_b--;
      we_b = 1'($urandom); addr_b = 8'($urandom); wdata_b = $urandom;
    end else if (qb.size() > 0) begin
      req_b = 1'b1; we_b = qb[0].we; addr_b = qb[0].addr; wdata_b = qb[0].wdata;
    end else begin
      req_b = 1'b0;
      we_b = 1'($urandom); addr_b = 8'($urandom); wdata_b = $urandom;
    end
  endtask

  // Sample outputs after the edge and compare with the model.
  task automatic cycle_check();
    bit e_issue, e_ack;
    @(posedge clk);
    #1;
    cyc++;
    e_issue = pend_valid && (cyc == pend_g + 1);
    e_ack   = pend_valid && (cyc == pend_g + 2);
    if (ram_we === 1'b1) we_cycles++;
    if (ack_a === 1'b1 || ack_b === 1'b1) begin
      ack_log.push_back('{port: (ack_b === 1'b1), cyc: cyc, data: rd_data});
      $display("cycle %0d: ack port %s rd_data=%h", cyc, (ack_b === 1'b1) ? "B" : "A", rd_data);
    end
    chk("ack_a",   32'(ack_a),  32'(e_ack && pend_port == 1'b0));
    chk("ack_b",   32'(ack_b),  32'(e_ack && pend_port == 1'b1));
    chk("ack_overlap", 32'(ack_a & ack_b), 32'd0);
    chk("busy",    32'(busy),   32'(e_issue || e_ack));
    chk("ram_we",  32'(ram_we), 32'(e_issue && pend_we));
    chk("ram_re",  32'(ram_re), 32'(e_issue && !pend_we));
    if (e_issue) begin
      chk("ram_addr", 32'(ram_addr), 32'(pend_addr));
      if (pend_we) chk("ram_wdata", ram_wdata, pend_wdata);
    end
    if (e_ack) begin
      if (pend_we) shadow[int'(pend_addr)] = pend_wdata;
      else chk("rd_data", rd_data, shadow_rd(int'(pend_addr)));
      if (pend_port == 1'b0) begin
        void'(qa.pop_front());
        if (qa.size() > 0) wait_a = qa[0].delay;
      end else begin
        void'(qb.pop_front());
        if (qb.size() > 0) wait_b = qb[0].delay;
      end
    end
  endtask

  // Decide, from the requests now on the ports, whether a grant happens at
  // the coming edge and which port wins.
  task automatic arbitrate();
    bit can, acked, done_port, el_a, el_b, w;
    acked = pend_valid && (cyc == pend_g + 2);
    can   = !pend_valid || acked;
    done_port = pend_port;
    if (acked) pend_valid = 1'b0;
    el_a = req_a && !(acked && done_port == 1'b0);
    el_b = req_b && !(acked && done_port == 1'b1);
    if (can && (el_a || el_b)) begin
      if (el_a && el_b) w = ~last_port;
      else              w = el_b;
      last_port  = w;
      pend_valid = 1'b1;
      pend_port  = w;
      pend_g     = cyc;
      pend_we    = w ? we_b : we_a;
      pend_addr  = w ? addr_b : addr_a;
      pend_wdata = w ? wdata_b : wdata_a;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_check();
      drive_ports();
      arbitrate();
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || pend_valid) && n < bound) begin
      run(1);
      n++;
    end
    checks++;
    assert (n < bound) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d cycles required below %0d", n, bound);
    end
  endtask

  task automatic do_reset();
    #1 clr = 1'b1;
    #1;
    chk("rst_ack_a",     32'(ack_a),     32'd0);
    chk("rst_ack_b",     32'(ack_b),     32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_re",    32'(ram_re),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_ram_wdata", ram_wdata,      32'd0);
    clr = 1'b0;
    pend_valid = 1'b0;
    last_port  = 1'b1;
  endtask

  initial begin
    int t0;
    clr = 1'b1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    wait_a = 0; wait_b = 0;
    pend_valid = 0; pend_port = 0; pend_g = 0; pend_we = 0;
    pend_addr = 0; pend_wdata = 0; last_port = 1'b1;
    #1;
    chk("rst0_busy",   32'(busy),   32'd0);
    chk("rst0_ram_re", 32'(ram_re), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // A writes DEADBEEF to 0x10 then reads it back.
    ack_log.delete(); we_cycles = 0; t0 = cyc + 1;
    push(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 0);
    push(1'b0, 1'b0, 8'h10, 32'h0, 0);
    drain(50);
    chk("034_acks",      32'(ack_log.size()), 32'd2);
    chk("034_we_cycles", 32'(we_cycles),      32'd1);
    if (ack_log.size() >= 2) begin
      chk("034_wr_ack_cyc", 32'(ack_log[0].cyc), 32'(t0 + 2));
      chk("034_rd_ack_cyc", 32'(ack_log[1].cyc), 32'(t0 + 5));
      chk("034_rd_data",    ack_log[1].data,     32'hDEADBEEF);
    end

    // Simultaneous requests straight after reset: A first, then B.
    do_reset();
    ack_log.delete(); t0 = cyc + 1;
    push(1'b0, 1'b0, 8'h01, 32'h0, 0);
    push(1'b1, 1'b0, 8'h02, 32'h0, 0);
    drain(50);
    chk("035_acks", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      chk("035_first_port",  32'(ack_log[0].port), 32'd0);
      chk("035_first_cyc",   32'(ack_log[0].cyc),  32'(t0 + 2));
      chk("035_second_port", 32'(ack_log[1].port), 32'd1);
      chk("035_second_cyc",  32'(ack_log[1].cyc),  32'(t0 + 4));
    end

    // Continuous requests from both ports: strict alternation every 2 cycles.
    ack_log.delete(); t0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b0, 8'(i), 32'h0, 0);
      push(1'b1, 1'b0, 8'(i + 8), 32'h0, 0);
    end
    drain(100);
    chk("036_acks", 32'(ack_log.size()), 32'd10);
    for (int i = 0; i < ack_log.size() && i < 10; i++) begin
      chk("036_port", 32'(ack_log[i].port), 32'(i % 2));
      chk("036_cyc",  32'(ack_log[i].cyc),  32'(t0 + 2 + 2 * i));
    end

    // B writes the top address; address 0 must be untouched.
    ack_log.delete();
    push(1'b1, 1'b1, 8'hFF, 32'h0000_0055, 0);
    push(1'b1, 1'b0, 8'hFF, 32'h0, 1);
    push(1'b1, 1'b0, 8'h00, 32'h0, 0);
    drain(50);
    chk("037_acks", 32'(ack_log.size()), 32'd3);
    if (ack_log.size() >= 3) begin
      chk("037_top_rd",  ack_log[1].data, 32'h0000_0055);
      chk("037_zero_rd", ack_log[2].data, init_val(0));
    end

    // Reset pulse in the ISSUE cycle of an A read aborts it; reissue completes.
    ack_log.delete();
    push(1'b0, 1'b0, 8'h10, 32'h0, 0);
    run(1);
    cycle_check();
    chk("038_re_in_issue", 32'(ram_re), 32'd1);
    #1 clr = 1'b1;
    #1;
    chk("038_re_dropped", 32'(ram_re), 32'd0);
    chk("038_no_ack_a",   32'(ack_a),  32'd0);
    chk("038_idle",       32'(busy),   32'd0);
    clr = 1'b0;
    pend_valid = 1'b0;
    last_port  = 1'b1;
    t0 = cyc;
    drive_ports();
    arbitrate();
    drain(50);
    chk("038_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() >= 1) begin
      chk("038_reissue_cyc",  32'(ack_log[0].cyc), 32'(t0 + 2));
      chk("038_reissue_data", ack_log[0].data,     32'hDEADBEEF);
    end

    // A alone with req held high: one read every 3 cycles.
    ack_log.delete(); t0 = cyc + 1;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'h10, 32'h0, 0);
    drain(50);
    chk("039_acks", 32'(ack_log.size()), 32'd3);
    for (int i = 0; i < ack_log.size() && i < 3; i++) begin
      chk("039_cyc", 32'(ack_log[i].cyc), 32'(t0 + 2 + 3 * i));
    end

    // Random mixed traffic on both ports.
    for (int i = 0; i < 40; i++) begin
      push(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
           int'($urandom_range(0, 3)));
      push(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
           int'($urandom_range(0, 3)));
    end
    drain(1500);
    run(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of the data bus on both requester ports and the RAM port.
REQ-002 Parameter ADDR_W, default 8: width of the address bus on both requester ports and the RAM port.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr  input  1  reset, asynchronous and active-high.
REQ-005 req_a / req_b  input  1 each  access request, port A (instruction fetch) / port B (data load/store).
REQ-006 we_a / we_b  input  1 each  1 = write, 0 = read.
REQ-007 addr_a / addr_b  input  ADDR_W each  access address.
REQ-008 wdata_a / wdata_b  input  DATA_W each  write data.
REQ-009 ack_a / ack_b  output  1 each  one-cycle completion pulse per granted access.
REQ-010 rd_data  output  DATA_W  read data, shared by both ports; valid only in the cycle an ack is high for a read.
REQ-011 ram_addr  output  ADDR_W  RAM address.
REQ-012 ram_wdata  output  DATA_W  RAM write data.
REQ-013 ram_we / ram_re  output  1 each  RAM write enable / RAM read enable.
REQ-014 ram_rdata  input  DATA_W  registered RAM output; updated at the posedge on which ram_re is sampled high.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-017 IDLE: if any req is high, the block SHALL select a winner, latch owner, addr, we and wdata into registers, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration: a single request wins; if both are requesting, the port not granted last SHALL win (two-way round-robin); last_grant updates on every grant.
REQ-019 ISSUE: exactly one of ram_we / ram_re SHALL be high (ram_we = latched we; ram_re = !latched we); ram_addr and ram_wdata SHALL equal the latched values; next state is RESP.
REQ-020 ram_we, ram_re, ram_addr and ram_wdata SHALL be driven only from registers and state decode, with no combinational path from req/addr inputs; enables are low outside ISSUE.
REQ-021 RESP: ack of the owner port SHALL be high for exactly this cycle; rd_data SHALL equal ram_rdata.
REQ-022 Latency: req seen in IDLE at cycle 0 -> ISSUE in cycle 1 -> ack in cycle 2.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until ack; the block ignores input changes after latching.
REQ-024 RESP re-arbitration: the block SHALL consider only the non-owner port's req (the owner's req is still high in its ack cycle); if that req is high, it SHALL latch it and go directly to ISSUE, otherwise to IDLE.
REQ-025 Throughput: with both ports requesting continuously, grants SHALL alternate A, B, A, ..., one access per 2 cycles after the first.
REQ-026 A port whose req stays high after its ack SHALL be treated as a new request and regranted at the next arbitration in which it is eligible.
REQ-027 ack_a and ack_b SHALL never be high in the same cycle, and neither SHALL be high outside RESP.
REQ-028 rd_data during a write ack is don't-care.

Reset
REQ-029 On clr, asynchronously: state = IDLE; ack_a = ack_b = 0; ram_we = ram_re = 0; busy = 0; ram_addr = 0; ram_wdata = 0; last_grant = B, so port A wins the first tie.
REQ-030 clr asserted during ISSUE or RESP SHALL abort the access with no ack; the requester must reissue it; whether a write completed to the RAM is unspecified.
REQ-031 After clr deasserts, the first arbitration SHALL occur on the next posedge on which state is IDLE.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP) and the port-ID constants PORT_A and PORT_B.
REQ-033 The two-way round-robin picker SHALL be the sub-module rr_arb2 (inputs: req_a, req_b, last_grant, enable; output: grant ID plus valid); the FSM and datapath registers stay in mem_arbiter.

Verification
REQ-034 Port A writes 0xDEADBEEF to address 0x10 and then reads 0x10 -> RAM model sees ram_we for one cycle; the read ack in cycle 2 carries rd_data = 0xDEADBEEF.
REQ-035 req_a and req_b both rise in the same cycle after reset -> A is acked in cycle 2 and B in cycle 4; ack_a and ack_b never overlap.
REQ-036 Both ports request continuously for 10 accesses -> grant order is A, B, A, B, ...; ack spacing is 2 cycles; each port gets 5 acks.
REQ-037 Port B writes 0x00000055 to address 0xFF (top address) -> B reads back 0x00000055; address 0x00 is unchanged.
REQ-038 clr pulsed during ISSUE of a port A read -> ram_re drops in the same cycle; no ack_a is issued; state is IDLE; a reissued read completes normally 2 cycles after grant.
REQ-039 Port A holds req_a high for 3 back-to-back reads with req_b low -> each read is acked with period 3 (RESP -> IDLE -> ISSUE).
